hack_ctrl: RTL

- Multi-cycle Hack CPU controller that drives the 16-bit ALU.
- It fetches 16-bit Hack instructions and holds the A, D and PC registers.
- It decodes C-instructions into the six ALU control bits (zx nx zy ny f no), consumes the ALU result and its zr/ng flags, and performs register/memory writeback and conditional jumps.
- The ALU is instantiated beside this block; instruction and data memories sit behind req/ack handshakes.

---
 rtl/hack_pkg.sv | 28 ++
 rtl/hack_jump.sv | 12 +
 rtl/hack_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: FSM states, instruction
// field positions and common ALU control encodings.
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MREAD  = 3'd2,
        ALU    = 3'd3,
        MWRITE = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam int BIT_CINST = 15;
    localparam int BIT_A     = 12;
    localparam int CTRL_HI   = 11;
    localparam int CTRL_LO   = 6;
    localparam int D1        = 5;
    localparam int D2        = 4;
    localparam int D3        = 3;
    localparam int J_HI      = 2;
    localparam int J_LO      = 0;

    localparam logic [5:0] ALU_ZERO      = 6'b101010;
    localparam logic [5:0] ALU_D_PLUS_A  = 6'b000010;
    localparam logic [5:0] ALU_D_MINUS_1 = 6'b001110;

endpackage

// File: rtl/hack_jump.sv
// Jump condition for a Hack C-instruction from the j-bits and the ALU flags.
// Purely combinational, no latency, no flow control.
module hack_jump (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       taken
);

    assign taken = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack CPU controller (A/D/PC, decode, writeback, jumps) driving an external ALU.
// Latency with zero-wait memory: A-inst 2 cycles, C-inst 3, +1 per M read, +1 per M write.
// Memories stall the FSM by withholding ack; HACK_CTRL_HALT_EN adds a HALT state on self-jump.
module hack_ctrl
    import hack_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [15:0]       dmem_rdata,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [15:0]       alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [15:0]       pc,
    output logic              halted
);

    state_t            r_state;
    logic [15:0]       r_pc;
    logic [15:0]       r_a;
    logic [15:0]       r_d;
    logic [15:0]       r_ir;
    logic [15:0]       r_m;
    logic [15:0]       r_w;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_imem_req;
    logic              r_dmem_req;
    logic              r_dmem_we;

    logic              w_taken;
    logic [15:0]       w_pc_inc;

    assign w_pc_inc = r_pc + 16'd1;

    hack_jump u_jump (
        .j     (r_ir[J_HI:J_LO]),
        .zr    (alu_zr),
        .ng    (alu_ng),
        .taken (w_taken)
    );

`ifdef HACK_CTRL_HALT_EN
    logic w_halt_hit;
    assign w_halt_hit = (r_ir[J_HI:J_LO] == 3'b111) && (r_a == r_pc);
    assign halted     = (r_state == HALT);
`else
    assign halted     = 1'b0;
`endif

    // Requests are registered, so the first fetch after reset starts one cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_a        <= 16'h0000;
            r_d        <= 16'h0000;
            r_ir       <= 16'h0000;
            r_m        <= 16'h0000;
            r_w        <= 16'h0000;
            r_waddr    <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= EXEC;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!r_ir[BIT_CINST]) begin
                        r_a        <= {1'b0, r_ir[14:0]};
                        r_pc       <= w_pc_inc;
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end else if (r_ir[BIT_A]) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= 1'b0;
                        r_state    <= MREAD;
                    end else begin
                        r_state    <= ALU;
                    end
                end
                MREAD: begin
                    if (r_dmem_req && dmem_ack) begin
                        r_m        <= dmem_rdata;
                        r_dmem_req <= 1'b0;
                        r_state    <= ALU;
                    end
                end
                ALU: begin
                    // Jump target and write address use A as it was before this edge.
                    if (r_ir[D1]) r_a <= alu_out;
                    if (r_ir[D2]) r_d <= alu_out;
                    r_pc <= w_taken ? r_a : w_pc_inc;
`ifdef HACK_CTRL_HALT_EN
                    if (w_halt_hit) begin
                        r_state <= HALT;
                    end else
`endif
                    if (r_ir[D3]) begin
                        r_w        <= alu_out;
                        r_waddr    <= r_a[ADDR_W-1:0];
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= 1'b1;
                        r_state    <= MWRITE;
                    end else begin
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                MWRITE: begin
                    if (r_dmem_req && dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc[ADDR_W-1:0];
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = (r_state == MWRITE) ? r_waddr : r_a[ADDR_W-1:0];
    assign dmem_wdata = r_w;
    assign alu_x      = r_d;
    assign alu_y      = r_ir[BIT_A] ? r_m : r_a;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = r_ir[CTRL_HI:CTRL_LO];
    assign pc         = r_pc;

endmodule
